// File: rtl/axifull_to_axis_pkg.sv
// Shared types and constants for the AXI4 read burst to AXI-Stream bridge.
package axifull_to_axis_pkg;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned KEEP_W = 8;
   localparam int unsigned LEN_W  = 16;
   localparam int unsigned BEAT_W = 14;
   localparam int unsigned DEST_W = 3;

   localparam logic [2:0] SIZE_8B       = 3'b011;
   localparam logic [1:0] BURST_INCR    = 2'b01;
   localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
   localparam logic [1:0] RESP_OKAY     = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADDR  = 2'd1,
      ST_DATA  = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
      logic [KEEP_W-1:0] keep;
      logic              user;
   } axis_beat_t;

   // Byte-enable pattern for the final beat of a packet of the given length.
   function automatic logic [KEEP_W-1:0] keep_from_len(input logic [2:0] len_lo);
      logic [KEEP_W-1:0] keep;
      if (len_lo == 3'd0) keep = 8'hFF;
      else                keep = KEEP_W'((9'd1 << len_lo) - 9'd1);
      return keep;
   endfunction

endpackage

// File: rtl/axifull_to_axis_if.sv
// AXI4 read channels plus the AXI-Stream output, bundled for the bridge.
interface axifull_to_axis_if #(
   parameter int unsigned ID_W   = 1,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 64
);
   logic [ID_W-1:0]   M_AXI_ARID;
   logic [ADDR_W-1:0] M_AXI_ARADDR;
   logic [7:0]        M_AXI_ARLEN;
   logic [2:0]        M_AXI_ARSIZE;
   logic [1:0]        M_AXI_ARBURST;
   logic              M_AXI_ARLOCK;
   logic [3:0]        M_AXI_ARCACHE;
   logic [2:0]        M_AXI_ARPROT;
   logic [3:0]        M_AXI_ARQOS;
   logic              M_AXI_ARVALID;
   logic              M_AXI_ARREADY;
   logic [ID_W-1:0]   M_AXI_RID;
   logic [DATA_W-1:0] M_AXI_RDATA;
   logic [1:0]        M_AXI_RRESP;
   logic              M_AXI_RLAST;
   logic              M_AXI_RVALID;
   logic              M_AXI_RREADY;

   logic              m_axis_tvalid;
   logic [DATA_W-1:0] m_axis_tdata;
   logic              m_axis_tlast;
   logic [7:0]        m_axis_tkeep;
   logic              m_axis_tuser;
   logic [2:0]        m_axis_tdest;
   logic              m_axis_tready;

   modport master (
      output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
             M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARVALID,
             M_AXI_RREADY,
             m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tkeep, m_axis_tuser,
             m_axis_tdest,
      input  M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
             M_AXI_RVALID, m_axis_tready
   );

   modport slave (
      input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
             M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARVALID,
             M_AXI_RREADY,
             m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tkeep, m_axis_tuser,
             m_axis_tdest,
      output M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
             M_AXI_RVALID, m_axis_tready
   );
endinterface

// File: rtl/axifull_to_axis_axis_out_reg.sv
// Single-entry AXI-Stream output register; reloads in the same cycle it drains.
module axifull_to_axis_axis_out_reg
   import axifull_to_axis_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  axis_beat_t beat_i,
   input  logic       tready_i,
   output logic       ready_c,
   output logic       tvalid,
   output axis_beat_t beat_o
);
   logic       valid_q, valid_d;
   axis_beat_t beat_q, beat_d;

   assign ready_c = ~valid_q | tready_i;
   assign tvalid  = valid_q;
   assign beat_o  = beat_q;

   always_comb begin
      valid_d = valid_q;
      beat_d  = beat_q;
      if (load_i) begin
         valid_d = 1'b1;
         beat_d  = beat_i;
      end else if (tready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         beat_q  <= '0;
      end else begin
         valid_q <= valid_d;
         beat_q  <= beat_d;
      end
   end
endmodule

// File: rtl/axifull_to_axis.sv
// Reads a byte range from AXI4 memory in aligned INCR bursts and emits one AXI-Stream packet.
// Optional AXIFULL_TO_AXIS_RRESP_CHECK_EN: flag R-channel errors on m_axis_tuser (sticky per packet).
module axifull_to_axis
   import axifull_to_axis_pkg::*;
#(
   parameter int unsigned C_M_AXI_BURST_LEN  = 16,
   parameter int unsigned C_M_AXI_ID_WIDTH   = 1,
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
   parameter int unsigned C_M_AXI_DATA_WIDTH = 64
) (
   input  logic                          M_AXI_ACLK,
   input  logic                          M_AXI_ARESETN,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_W-1:0]              cmd_len,
   input  logic [DEST_W-1:0]             cmd_dest,
   output logic                          busy,
   axifull_to_axis_if.master             bus
);
   localparam int unsigned ADDR_W = C_M_AXI_ADDR_WIDTH;
   localparam int unsigned BPB    = C_M_AXI_DATA_WIDTH / 8;
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(C_M_AXI_BURST_LEN * BPB - 1);
   localparam logic [BEAT_W-1:0] MAX_BEATS  = BEAT_W'(C_M_AXI_BURST_LEN);

   state_e              state_q, state_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic                busy_q, busy_d;
   logic                arvalid_q, arvalid_d;
   logic [ADDR_W-1:0]   araddr_q, araddr_d;
   logic [7:0]          arlen_q, arlen_d;
   logic [BEAT_W-1:0]   remaining_q, remaining_d;
   logic [BEAT_W-1:0]   total_q, total_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [KEEP_W-1:0]   last_keep_q, last_keep_d;
   logic [DEST_W-1:0]   dest_q, dest_d;

   logic       out_ready_c, rready_c, r_hs_c, ar_hs_c, cmd_hs_c, is_last_c, resp_err_c;
   logic       tvalid;
   logic [BEAT_W-1:0] cmd_beats_c;
   axis_beat_t beat_c, beat_out;

   function automatic logic [7:0] arlen_for(input logic [BEAT_W-1:0] rem);
      return 8'(((rem > MAX_BEATS) ? MAX_BEATS : rem) - BEAT_W'(1));
   endfunction

   assign rready_c    = (state_q == ST_DATA) & out_ready_c;
   assign r_hs_c      = bus.M_AXI_RVALID & rready_c;
   assign ar_hs_c     = arvalid_q & bus.M_AXI_ARREADY;
   assign cmd_hs_c    = cmd_valid & cmd_ready_q;
   assign cmd_beats_c = BEAT_W'((17'(cmd_len) + 17'd7) >> 3);
   assign is_last_c   = (beat_q == total_q - BEAT_W'(1));
   assign resp_err_c  = (bus.M_AXI_RRESP != RESP_OKAY);

`ifdef AXIFULL_TO_AXIS_RRESP_CHECK_EN
   logic err_q, err_d;
   logic unused_rid;
   assign unused_rid = ^bus.M_AXI_RID;
   assign beat_c.user = err_q | resp_err_c;
`else
   logic unused_r;
   assign unused_r = ^{bus.M_AXI_RID, resp_err_c};
   assign beat_c.user = 1'b0;
`endif
   assign beat_c.data = bus.M_AXI_RDATA;
   assign beat_c.last = is_last_c;
   assign beat_c.keep = is_last_c ? last_keep_q : 8'hFF;

   // Burst sequencing: one AR outstanding, next AR issued right after RLAST.
   always_comb begin
      state_d     = state_q;
      araddr_d    = araddr_q;
      arlen_d     = arlen_q;
      remaining_d = remaining_q;
      total_d     = total_q;
      beat_d      = beat_q;
      last_keep_d = last_keep_q;
      dest_d      = dest_q;
`ifdef AXIFULL_TO_AXIS_RRESP_CHECK_EN
      err_d       = err_q;
      if (r_hs_c && resp_err_c) err_d = 1'b1;
`endif
      if (r_hs_c) beat_d = beat_q + BEAT_W'(1);
      case (state_q)
         ST_IDLE: begin
            if (cmd_hs_c && (cmd_len != '0)) begin
               total_d     = cmd_beats_c;
               remaining_d = cmd_beats_c;
               beat_d      = '0;
               last_keep_d = keep_from_len(cmd_len[2:0]);
               dest_d      = cmd_dest;
               araddr_d    = cmd_addr & ALIGN_MASK;
               arlen_d     = arlen_for(cmd_beats_c);
`ifdef AXIFULL_TO_AXIS_RRESP_CHECK_EN
               err_d       = 1'b0;
`endif
               state_d     = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (ar_hs_c) begin
               araddr_d    = araddr_q + (ADDR_W'(arlen_q) + ADDR_W'(1)) * ADDR_W'(BPB);
               remaining_d = remaining_q - (BEAT_W'(arlen_q) + BEAT_W'(1));
               state_d     = ST_DATA;
            end
         end
         ST_DATA: begin
            if (r_hs_c && bus.M_AXI_RLAST) begin
               if (remaining_q != '0) begin
                  arlen_d = arlen_for(remaining_q);
                  state_d = ST_ADDR;
               end else begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (!tvalid || bus.m_axis_tready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      cmd_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
      arvalid_d   = (state_d == ST_ADDR);
   end

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         arvalid_q   <= 1'b0;
         araddr_q    <= '0;
         arlen_q     <= '0;
         remaining_q <= '0;
         total_q     <= '0;
         beat_q      <= '0;
         last_keep_q <= '0;
         dest_q      <= '0;
`ifdef AXIFULL_TO_AXIS_RRESP_CHECK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
         arvalid_q   <= arvalid_d;
         araddr_q    <= araddr_d;
         arlen_q     <= arlen_d;
         remaining_q <= remaining_d;
         total_q     <= total_d;
         beat_q      <= beat_d;
         last_keep_q <= last_keep_d;
         dest_q      <= dest_d;
`ifdef AXIFULL_TO_AXIS_RRESP_CHECK_EN
         err_q       <= err_d;
`endif
      end
   end

   axifull_to_axis_axis_out_reg u_axis_out_reg (
      .clk      (M_AXI_ACLK),
      .rst_n    (M_AXI_ARESETN),
      .load_i   (r_hs_c),
      .beat_i   (beat_c),
      .tready_i (bus.m_axis_tready),
      .ready_c  (out_ready_c),
      .tvalid   (tvalid),
      .beat_o   (beat_out)
   );

   assign cmd_ready         = cmd_ready_q;
   assign busy              = busy_q;
   assign bus.M_AXI_ARID    = C_M_AXI_ID_WIDTH'(0);
   assign bus.M_AXI_ARADDR  = araddr_q;
   assign bus.M_AXI_ARLEN   = arlen_q;
   assign bus.M_AXI_ARSIZE  = SIZE_8B;
   assign bus.M_AXI_ARBURST = BURST_INCR;
   assign bus.M_AXI_ARLOCK  = 1'b0;
   assign bus.M_AXI_ARCACHE = CACHE_DEFAULT;
   assign bus.M_AXI_ARPROT  = 3'b000;
   assign bus.M_AXI_ARQOS   = 4'b0000;
   assign bus.M_AXI_ARVALID = arvalid_q;
   assign bus.M_AXI_RREADY  = rready_c;
   assign bus.m_axis_tvalid = tvalid;
   assign bus.m_axis_tdata  = beat_out.data;
   assign bus.m_axis_tlast  = beat_out.last;
   assign bus.m_axis_tkeep  = beat_out.keep;
   assign bus.m_axis_tuser  = beat_out.user;
   assign bus.m_axis_tdest  = dest_q;
endmodule

// File: doc/axifull_to_axis.md
# axifull_to_axis

Read-side companion to the stream-to-memory writer. Accepts a read command (base address, byte length, destination tag), fetches the data from an AXI4 slave with INCR bursts of up to C_M_AXI_BURST_LEN beats, and emits it as a 64-bit AXI-Stream packet with correct tlast and tkeep. It sits between the DDR/AXI interconnect and the stream-side packet logic that consumes buffered frames.

## Interface
- C_M_AXI_BURST_LEN, 16: maximum beats per AR burst; supported values are 1, 2, 4, 8, 16, 32, 64, 128, 256.
- C_M_AXI_ID_WIDTH, 1: ARID/RID width.
- C_M_AXI_ADDR_WIDTH, 32: address width.
- C_M_AXI_DATA_WIDTH, 64: data width. Fixed at 64.
- M_AXI_ACLK  in  1  single clock for all logic.
- M_AXI_ARESETN  in  1  reset, asynchronous, active-low.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  start byte address. Low log2(BURST_LEN*8) bits are forced to 0.
- cmd_len  in  16  packet length in bytes.
- cmd_dest  in  3  copied to m_axis_tdest for the whole packet.
- M_AXI_ARID, ARADDR, ARLEN[7:0], ARSIZE[2:0], ARBURST[1:0], ARLOCK, ARCACHE[3:0], ARPROT[2:0], ARQOS[3:0], ARVALID  out: AXI4 read address channel.
- M_AXI_ARREADY  in  1.
- M_AXI_RID, RDATA[63:0], RRESP[1:0], RLAST, RVALID  in: AXI4 read data channel.
- M_AXI_RREADY  out  1.
- m_axis_tvalid, m_axis_tdata[63:0], m_axis_tlast, m_axis_tkeep[7:0], m_axis_tuser, m_axis_tdest[2:0]  out.
- m_axis_tready  in  1.
- busy  out  1  high from command accept until the final stream beat is transferred.

## Operation
- Constant outputs: ARID=0, ARSIZE=3'b011, ARBURST=2'b01 (INCR), ARLOCK=0, ARCACHE=4'b0011, ARPROT=0, ARQOS=0.
- Total beats: N = (cmd_len+7)>>3, held in a 14-bit counter. Last-beat keep: cmd_len[2:0]==0 gives 8'hFF; otherwise (1<<cmd_len[2:0])-1.
- FSM states:
  - IDLE: cmd_ready=1. On handshake, latch the command. If cmd_len==0, drop it and stay in IDLE. Otherwise go to ADDR.
  - ADDR: ARVALID=1 with ARLEN=min(remaining,BURST_LEN)-1. On ARREADY, add burst*8 to the address, subtract burst from remaining, and go to DATA.
  - DATA: accept R beats. On the RLAST handshake, go to ADDR if remaining>0. If remaining==0, go to DRAIN.
  - DRAIN: wait for the output register to empty, then go to IDLE.
- Only one burst is outstanding at a time. RID is ignored.
- The output is a single register stage. M_AXI_RREADY = (state==DATA) & (~m_axis_tvalid | m_axis_tready).
- On each R handshake, load tdata and set tkeep=8'hFF.
- On the packet's final beat (beat counter == N-1), set tlast=1 and tkeep=last-beat keep.
- tvalid, tdata, tlast, tkeep and tuser are held stable while tvalid=1 and tready=0.
- The address is aligned to BURST_LEN*8 bytes, so bursts never cross a 4 KB boundary.

## Timing
- Reset values: all valids 0, cmd_ready 0 during reset and 1 in IDLE afterwards, busy 0, ARADDR 0, ARLEN 0, m_axis_* 0.
- Command accepted at cycle T gives ARVALID=1 at T+1.
- An R handshake at cycle t gives m_axis_tvalid=1 at t+1. With tready held at 1, throughput is one beat per cycle.
- An RLAST handshake at t, with beats remaining, gives ARVALID at t+1. The gap between bursts is address latency plus 1 cycle.
- busy falls in the cycle after the tlast handshake. cmd_ready rises in that same cycle.
- If tready is low when RVALID arrives, RREADY stays low and the beat is not lost.
- Simultaneous output handshake and new R beat in the same cycle: the register reloads with no bubble.
- Reset asserted mid-burst: every output clears immediately and the FSM returns to IDLE. The interconnect shares M_AXI_ARESETN, so the in-flight transaction is discarded.

## Configuration
- AXIFULL_TO_AXIS_RRESP_CHECK_EN defined:
  - A sticky error bit sets on any R beat with RRESP!=2'b00.
  - m_axis_tuser is driven with (error | current RRESP!=0) on every beat.
  - The error bit clears when the next command is accepted.
- AXIFULL_TO_AXIS_RRESP_CHECK_EN undefined: RRESP is ignored and m_axis_tuser is tied to 0.

## Structure
- Shared package holds:
  - AXI constants: SIZE_8B, BURST_INCR, CACHE_DEFAULT, RESP_OKAY.
  - The FSM state enum.
  - A keep_from_len(len[2:0]) function.
- One natural sub-module, axis_out_reg: the single-entry output register with its tready/tvalid logic.
- Burst sequencing stays in the top module.

## Test plan
- cmd_len=128, addr=0x1000, tready=1 -> one AR with ARLEN=15, ARADDR=0x1000. Then 16 stream beats, tlast on beat 16, tkeep=0xFF.
- cmd_len=300 -> ARs with ARLEN=15, 15, 5 at 0x0, 0x80, 0x100. Then 38 beats, last tkeep=0x0F, tlast only on beat 38.
- cmd_len=60, with tready toggled 1-0-0-1 -> RREADY tracks the output state, no beat lost or duplicated, data matches memory.
- cmd_len=0 -> no ARVALID, no stream output, cmd_ready back to 1 next cycle.
- RRESP=2'b10 on beat 3 with the macro defined -> tuser=1 from beat 3 through tlast. The next command starts with tuser=0.
- ARESETN pulsed low mid-burst -> all outputs 0 asynchronously. After release, a new 8-byte command yields ARLEN=0 and one beat with tkeep=0xFF, tlast=1.
